// File: rtl/reg_dump_pkg.sv
// ============================================================================
// Module   : reg_dump_pkg
// Brief    : Shared types and constants for the MIPS state-dump unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    HDR  = 3'd2,
    SEND = 3'd3,
    LOAD = 3'd4,
    SUM  = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [7:0] DUMP_HDR       = 8'hA5;
  localparam int         FRAME_BYTES    = 134;
  localparam int         DUMP_DATA_W    = 32;
  localparam int         BYTES_PER_WORD = DUMP_DATA_W / 8;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_dump_if.sv
// ============================================================================
// Module   : reg_dump_if
// Brief    : Byte stream valid/ready channel carrying the dump frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reg_dump_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

`default_nettype wire

// File: rtl/reg_dump_word_ser.sv
// ============================================================================
// Module   : word_ser
// Brief    : Word-to-byte shift serializer, most significant byte first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_ser
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] load_data,
  input  wire logic              shift,
  output logic      [7:0]        byte_out,
  output logic                   last
);

  localparam int c_bpw   = bytes_per_word(DATA_W);
  localparam int c_cnt_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;

  logic [DATA_W-1:0]  r_sreg;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (load) begin
      r_sreg <= load_data;
      r_cnt  <= '0;
    end else if (shift) begin
      r_sreg <= r_sreg << 8;
      r_cnt  <= r_cnt + c_cnt_w'(1);
    end
  end

  assign byte_out = r_sreg[DATA_W-1 -: 8];
  assign last     = (r_cnt == c_cnt_w'(c_bpw - 1));

endmodule

`default_nettype wire

// File: rtl/reg_dump.sv
// ============================================================================
// Module   : reg_dump
// Brief    : Halts the CPU and streams header, PC, register file and checksum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_dump
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              start,
  output logic                   busy,
  output logic                   halt_req,
  input  wire logic [DATA_W-1:0] pc_in,
  output logic      [4:0]        rf_addr,
  input  wire logic [DATA_W-1:0] rf_data,
  reg_dump_if.master             tx,
  output logic                   done
);

  localparam int c_idx_w = $clog2(NUM_REGS + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [4:0]          r_rf_addr;
  logic [c_idx_w-1:0]  r_words;
  logic [7:0]          r_csum;

  logic                w_hs;
  logic                w_ser_load;
  logic [DATA_W-1:0]   w_ser_data;
  logic                w_ser_shift;
  logic [7:0]          w_ser_byte;
  logic                w_ser_last;
  logic                w_regs_left;

  // tx_valid is decoded from state only, so the handshake never loops back.
  assign w_hs        = tx.tx_valid && tx.tx_ready;
  assign w_regs_left = (r_words < c_idx_w'(NUM_REGS));
  assign w_ser_load  = (r_state == HALT) || (r_state == LOAD);
  assign w_ser_data  = (r_state == HALT) ? pc_in : rf_data;
  assign w_ser_shift = (r_state == SEND) && w_hs;

  word_ser #(
    .DATA_W    (DATA_W)
  ) u_word_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_ser_load),
    .load_data (w_ser_data),
    .shift     (w_ser_shift),
    .byte_out  (w_ser_byte),
    .last      (w_ser_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = HALT;
      HALT: w_state_nxt = HDR;
      HDR:  if (w_hs) w_state_nxt = SEND;
      SEND: if (w_hs && w_ser_last) w_state_nxt = w_regs_left ? LOAD : SUM;
      LOAD: w_state_nxt = SEND;
      SUM:  if (w_hs) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    halt_req    = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    done        = 1'b0;
    if (r_state != IDLE) begin
      busy     = 1'b1;
      halt_req = 1'b1;
    end
    case (r_state)
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = DUMP_HDR;
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = w_ser_byte;
      end
      SUM: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = r_csum;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Read address saturates at the last register and is rewound on the next dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_addr <= '0;
      r_words   <= '0;
      r_csum    <= '0;
    end else begin
      case (r_state)
        HALT: begin
          r_rf_addr <= '0;
          r_words   <= '0;
          r_csum    <= '0;
        end
        SEND: if (w_hs) r_csum <= r_csum ^ w_ser_byte;
        LOAD: begin
          r_words <= r_words + c_idx_w'(1);
          if (r_rf_addr != 5'(NUM_REGS - 1)) r_rf_addr <= r_rf_addr + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign rf_addr = r_rf_addr;

endmodule

`default_nettype wire
